// File: rtl/fifo_pkg.sv
`default_nettype none
// ==========================================================================
// Module  : fifo_pkg
// Brief   : Shared defaults, read-side FSM states and word type for the packer
// Revision: 1.0 - initial release
// ==========================================================================
package fifo_pkg;

  localparam int FIFO_DATA_W    = 8;
  localparam int FIFO_PACK      = 4;
  localparam int FIFO_BURST_LEN = 4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_PAD   = 2'd2,
    ST_DONE  = 2'd3
  } rd_state_e;

  typedef struct packed {
    logic [FIFO_DATA_W*FIFO_PACK-1:0] data;
    logic [FIFO_PACK-1:0]             keep;
    logic                             last;
  } word_t;

endpackage
`default_nettype wire

// File: rtl/fifo_skid_buf.sv
`default_nettype none
// ==========================================================================
// Module  : fifo_skid_buf
// Brief   : Two-entry word buffer; push and pop may share a cycle
// Revision: 1.0 - initial release
// ==========================================================================
module fifo_skid_buf #(
  parameter type WORD_T = fifo_pkg::word_t
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  WORD_T      push_word,
  input  logic       pop,
  output WORD_T      head,
  output logic [1:0] count
);

  WORD_T      ent_q [2];
  WORD_T      ent_d [2];
  logic [1:0] cnt_q;
  logic [1:0] cnt_d;

  always_comb begin
    ent_d[0] = ent_q[0];
    ent_d[1] = ent_q[1];
    cnt_d    = cnt_q;
    if (pop && cnt_q != 2'd0) begin
      ent_d[0] = ent_q[1];
      cnt_d    = cnt_q - 2'd1;
    end
    // Pop is applied first so a push into a full buffer that also pops lands in the freed slot.
    if (push && cnt_d != 2'd2) begin
      ent_d[cnt_d[0]] = push_word;
      cnt_d           = cnt_d + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_q[0] <= '0;
      ent_q[1] <= '0;
      cnt_q    <= 2'd0;
    end else begin
      ent_q[0] <= ent_d[0];
      ent_q[1] <= ent_d[1];
      cnt_q    <= cnt_d;
    end
  end

  assign head  = ent_q[0];
  assign count = cnt_q;

endmodule
`default_nettype wire

// File: rtl/fifo_pack_reader.sv
`default_nettype none
// ==========================================================================
// Module  : fifo_pack_reader
// Brief   : Pops FIFO bytes, packs them little-endian into burst-framed words
// Revision: 1.0 - initial release
// ==========================================================================
module fifo_pack_reader
  import fifo_pkg::*;
#(
  parameter int DATA_W    = FIFO_DATA_W,
  parameter int PACK      = FIFO_PACK,
  parameter int BURST_LEN = FIFO_BURST_LEN
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   empty,
  output logic                   rd_en,
  input  logic [DATA_W-1:0]      rd_data,
  input  logic                   flush,
  output logic                   flush_done,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W*PACK-1:0] out_data,
  output logic [PACK-1:0]        out_keep,
  output logic                   out_last
);

  localparam int BCW = $clog2(PACK);
  localparam int BUW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int WW  = DATA_W * PACK;

  localparam logic [BCW:0]   C_PACK      = (BCW+1)'(PACK);
  localparam logic [BCW:0]   C_PACK_M1   = (BCW+1)'(PACK - 1);
  localparam logic [BCW-1:0] C_LAST_LANE = BCW'(PACK - 1);
  localparam logic [BUW-1:0] C_LAST_BEAT = BUW'(BURST_LEN - 1);

  typedef struct packed {
    logic [WW-1:0]   data;
    logic [PACK-1:0] keep;
    logic            last;
  } pword_t;

  rd_state_e                  state_q, state_d;
  logic [BCW-1:0]             byte_cnt_q, byte_cnt_d;
  logic                       pend_q, pend_d;
  logic [(PACK-1)*DATA_W-1:0] lane_q, lane_d;
  logic [BUW-1:0]             burst_cnt_q, burst_cnt_d;

  logic [BCW:0] fill;
  logic         push;
  pword_t       push_word;
  pword_t       head;
  logic [1:0]   obuf_cnt;
  logic         pop;

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    lane_d      = lane_q;
    burst_cnt_d = burst_cnt_q;
    push        = 1'b0;
    push_word   = '0;
    flush_done  = 1'b0;

    fill  = {1'b0, byte_cnt_q} + {{BCW{1'b0}}, pend_q};
    // The last byte of a word may only be popped when the buffer has room for that word.
    rd_en = !rst && !empty && (state_q == ST_RUN) && (fill < C_PACK) &&
            ((fill < C_PACK_M1) || (obuf_cnt < 2'd2));
    pend_d = rd_en;

    if (pend_q) begin
      if (byte_cnt_q == C_LAST_LANE) begin
        push           = 1'b1;
        push_word.data = {rd_data, lane_q};
        push_word.keep = '1;
        push_word.last = (burst_cnt_q == C_LAST_BEAT);
        byte_cnt_d     = '0;
        burst_cnt_d    = push_word.last ? '0 : burst_cnt_q + BUW'(1);
      end else begin
        for (int i = 0; i < PACK - 1; i++) begin
          if (byte_cnt_q == BCW'(i)) lane_d[i*DATA_W +: DATA_W] = rd_data;
        end
        byte_cnt_d = byte_cnt_q + BCW'(1);
      end
    end

    case (state_q)
      ST_RUN: begin
        if (flush) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!pend_q) state_d = (byte_cnt_q != '0) ? ST_PAD : ST_DONE;
      end
      ST_PAD: begin
        if (obuf_cnt < 2'd2) begin
          push = 1'b1;
          for (int i = 0; i < PACK - 1; i++) begin
            if (BCW'(i) < byte_cnt_q) begin
              push_word.data[i*DATA_W +: DATA_W] = lane_q[i*DATA_W +: DATA_W];
              push_word.keep[i]                  = 1'b1;
            end
          end
          push_word.last = 1'b1;
          byte_cnt_d     = '0;
          burst_cnt_d    = '0;
          state_d        = ST_DONE;
        end
      end
      ST_DONE: begin
        flush_done = 1'b1;
        state_d    = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      byte_cnt_q  <= '0;
      pend_q      <= 1'b0;
      lane_q      <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      pend_q      <= pend_d;
      lane_q      <= lane_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  fifo_skid_buf #(
    .WORD_T (pword_t)
  ) u_obuf (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_word (push_word),
    .pop       (pop),
    .head      (head),
    .count     (obuf_cnt)
  );

  assign out_valid = (obuf_cnt != 2'd0);
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? head.data : '0;
  assign out_keep  = out_valid ? head.keep : '0;
  assign out_last  = out_valid ? head.last : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_fifo_pack_reader.sv
`default_nettype none
// ==========================================================================
// Module  : tb_fifo_pack_reader
// Brief   : Directed self-checking bench with a behavioural byte FIFO
// Revision: 1.0 - initial release
// ==========================================================================
module tb_fifo_pack_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        empty = 1'b1;
  logic        rd_en;
  logic [7:0]  rd_data = 8'h00;
  logic        flush = 1'b0;
  logic        flush_done;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_last;

  int n_run  = 0;
  int n_fail = 0;

  logic [7:0]  fq[$];
  logic [63:0] got[$];
  int          got_cyc[$];
  int          pop_cyc[$];
  int          cyc = 0;
  int          fd_cnt = 0;
  int          fd_cyc = -1;
  int          flush_cyc = -100;
  logic [7:0]  nxt_byte = 8'h00;
  logic        pop_pending = 1'b0;

  fifo_pack_reader dut (
    .clk        (clk),
    .rst        (rst),
    .empty      (empty),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .flush      (flush),
    .flush_done (flush_done),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_keep   (out_keep),
    .out_last   (out_last)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mkw(input logic last, input logic [3:0] keep, input logic [31:0] data);
    return {27'b0, last, keep, data};
  endfunction

  // Byte FIFO model and output monitor; sampling on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (rd_en && !empty) begin
        nxt_byte    = fq.pop_front();
        pop_pending = 1'b1;
        pop_cyc.push_back(cyc);
      end
      if (out_valid && out_ready) begin
        got.push_back(mkw(out_last, out_keep, out_data));
        got_cyc.push_back(cyc);
      end
      if (flush_done) begin
        fd_cnt++;
        fd_cyc = cyc;
      end
      if (flush) flush_cyc = cyc;
    end
  end

  always @(posedge clk) begin
    #1;
    if (pop_pending) begin
      rd_data     = nxt_byte;
      pop_pending = 1'b0;
    end
    empty = (fq.size() == 0);
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic ready);
    rst       = 1'b1;
    flush     = 1'b0;
    out_ready = ready;
    fq.delete();
    empty = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    got.delete();
    got_cyc.delete();
    pop_cyc.delete();
    fd_cnt = 0;
    fd_cyc = -1;
  endtask

  task automatic load_bytes(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) fq.push_back(first + 8'(i));
    empty = (fq.size() == 0);
  endtask

  task automatic wait_words(input int n, input int budget, input string tag);
    for (int i = 0; i < budget && got.size() < n; i++) @(posedge clk);
    #1;
    check_eq(tag, 64'(got.size()), 64'(n));
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  initial begin
    // 1: reset state then one full word
    do_reset(1'b1);
    check_eq("rst_rd_en", 64'(rd_en), 64'd0);
    check_eq("rst_valid", 64'(out_valid), 64'd0);
    check_eq("rst_fdone", 64'(flush_done), 64'd0);
    check_eq("rst_data", {27'b0, out_last, out_keep, out_data}, 64'd0);
    load_bytes(8'h01, 4);
    wait_words(1, 30, "t1_cnt");
    check_eq("t1_word", got[0], mkw(1'b0, 4'hF, 32'h04030201));

    // 2: streaming burst, last only on the 4th word, one-cycle pop gap per word
    do_reset(1'b1);
    load_bytes(8'h00, 16);
    wait_words(4, 60, "t2_cnt");
    check_eq("t2_w0", got[0], mkw(1'b0, 4'hF, 32'h03020100));
    check_eq("t2_w1", got[1], mkw(1'b0, 4'hF, 32'h07060504));
    check_eq("t2_w2", got[2], mkw(1'b0, 4'hF, 32'h0B0A0908));
    check_eq("t2_w3", got[3], mkw(1'b1, 4'hF, 32'h0F0E0D0C));
    check_eq("t2_pops", 64'(pop_cyc.size()), 64'd16);
    check_eq("t2_run4", 64'(pop_cyc[3] - pop_cyc[0]), 64'd3);
    check_eq("t2_gap1", 64'(pop_cyc[4] - pop_cyc[3]), 64'd2);
    check_eq("t2_gap2", 64'(pop_cyc[8] - pop_cyc[7]), 64'd2);

    // 3: backpressure stalls popping at fill==PACK-1 of the third word
    do_reset(1'b0);
    load_bytes(8'h10, 12);
    repeat (30) @(posedge clk);
    #1;
    check_eq("t3_pops", 64'(pop_cyc.size()), 64'd11);
    check_eq("t3_left", 64'(fq.size()), 64'd1);
    check_eq("t3_rd_en", 64'(rd_en), 64'd0);
    check_eq("t3_valid", 64'(out_valid), 64'd1);
    check_eq("t3_head", 64'(out_data), 64'h13121110);
    out_ready = 1'b1;
    wait_words(3, 30, "t3_cnt");
    check_eq("t3_w0", got[0], mkw(1'b0, 4'hF, 32'h13121110));
    check_eq("t3_w1", got[1], mkw(1'b0, 4'hF, 32'h17161514));
    check_eq("t3_w2", got[2], mkw(1'b0, 4'hF, 32'h1B1A1918));

    // 4: flush a 3-byte partial word, then a fresh burst
    do_reset(1'b1);
    fq.push_back(8'hAA);
    fq.push_back(8'hBB);
    fq.push_back(8'hCC);
    empty = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    pulse_flush();
    wait_words(1, 20, "t4_cnt");
    repeat (2) @(posedge clk);
    #1;
    check_eq("t4_word", got[0], mkw(1'b1, 4'b0111, 32'h00CCBBAA));
    check_eq("t4_fd_cnt", 64'(fd_cnt), 64'd1);
    check_eq("t4_fd_when", 64'(fd_cyc), 64'(got_cyc[0]));
    load_bytes(8'h20, 16);
    wait_words(5, 60, "t4_cnt2");
    check_eq("t4_b0", got[1], mkw(1'b0, 4'hF, 32'h23222120));
    check_eq("t4_b3", got[4], mkw(1'b1, 4'hF, 32'h2F2E2D2C));

    // 5: flush with nothing packed
    do_reset(1'b1);
    repeat (3) @(posedge clk);
    #1;
    pulse_flush();
    repeat (10) @(posedge clk);
    #1;
    check_eq("t5_words", 64'(got.size()), 64'd0);
    check_eq("t5_fd_cnt", 64'(fd_cnt), 64'd1);
    check_eq("t5_fd_lat", 64'(fd_cyc - flush_cyc), 64'd2);

    // 6: reset with a byte in flight and two words buffered
    do_reset(1'b0);
    load_bytes(8'h10, 12);
    for (int i = 0; i < 40 && pop_cyc.size() < 9; i++) begin
      @(posedge clk);
      #1;
    end
    check_eq("t6_pre_pops", 64'(pop_cyc.size()), 64'd9);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("t6_valid", 64'(out_valid), 64'd0);
    check_eq("t6_rd_en", 64'(rd_en), 64'd0);
    fq.delete();
    empty = 1'b1;
    got.delete();
    got_cyc.delete();
    pop_cyc.delete();
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    load_bytes(8'h51, 4);
    wait_words(1, 30, "t6_cnt");
    check_eq("t6_word", got[0], mkw(1'b0, 4'hF, 32'h54535251));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
